// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns one valid/ready register command into one AXI4-Lite write or read
// and returns one response per command, with an optional per-transaction timeout.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t          state_reg;
    logic            cmd_ready_reg;
    logic            busy_reg;
    logic            awvalid_reg;
    logic            wvalid_reg;
    logic            bready_reg;
    logic            arvalid_reg;
    logic            rready_reg;
    logic            aw_done_reg;
    logic            w_done_reg;
    logic [AW-1:0]   awaddr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [SW-1:0]   wstrb_reg;
    logic [AW-1:0]   araddr_reg;
    logic            rsp_valid_reg;
    logic [DW-1:0]   rsp_rdata_reg;
    logic [1:0]      rsp_resp_reg;
    logic            rsp_timeout_reg;
    logic [TW-1:0]   tmo_cnt_reg;

    logic aw_hs;
    logic w_hs;
    logic in_flight;
    logic progress;
    logic timeout_hit;

    assign aw_hs     = awvalid_reg & M_AXI_AWREADY;
    assign w_hs      = wvalid_reg & M_AXI_WREADY;
    assign in_flight = (state_reg == WR) || (state_reg == WR_RESP) ||
                       (state_reg == RD_ADDR) || (state_reg == RD_DATA);

    // A phase advancing this cycle beats a timeout landing on the same cycle.
    always_comb begin
        progress = 1'b0;
        case (state_reg)
            WR:      progress = (aw_done_reg | aw_hs) & (w_done_reg | w_hs);
            WR_RESP: progress = M_AXI_BVALID & bready_reg;
            RD_ADDR: progress = arvalid_reg & M_AXI_ARREADY;
            RD_DATA: progress = M_AXI_RVALID & rready_reg;
            default: progress = 1'b0;
        endcase
    end

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timeout
            assign timeout_hit = (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_reg       <= IDLE;
            cmd_ready_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            bready_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            rready_reg      <= 1'b0;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            awaddr_reg      <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            araddr_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= 2'b00;
            rsp_timeout_reg <= 1'b0;
            tmo_cnt_reg     <= '0;
        end else if (in_flight && timeout_hit && !progress) begin
            // Abandon the bus mid-transaction; the slave must be reset before it is used again.
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            bready_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            rready_reg      <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= 2'b10;
            rsp_timeout_reg <= 1'b1;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RSP;
        end else begin
            if (in_flight) begin
                tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
            end
            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_valid && cmd_ready_reg) begin
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        tmo_cnt_reg   <= '0;
                        if (cmd_write) begin
                            awaddr_reg  <= cmd_addr;
                            wdata_reg   <= cmd_wdata;
                            wstrb_reg   <= cmd_wstrb;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            aw_done_reg <= 1'b0;
                            w_done_reg  <= 1'b0;
                            state_reg   <= WR;
                        end else begin
                            araddr_reg  <= cmd_addr;
                            arvalid_reg <= 1'b1;
                            state_reg   <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_reg <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if (progress) begin
                        bready_reg <= 1'b1;
                        state_reg  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (progress) begin
                        bready_reg      <= 1'b0;
                        rsp_resp_reg    <= M_AXI_BRESP;
                        rsp_rdata_reg   <= '0;
                        rsp_timeout_reg <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        state_reg       <= RSP;
                    end
                end
                RD_ADDR: begin
                    if (progress) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (progress) begin
                        rready_reg      <= 1'b0;
                        rsp_rdata_reg   <= M_AXI_RDATA;
                        rsp_resp_reg    <= M_AXI_RRESP;
                        rsp_timeout_reg <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        state_reg       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_reg;
    assign busy          = busy_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;
    assign rsp_timeout   = rsp_timeout_reg;
    assign M_AXI_AWADDR  = awaddr_reg;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_reg;
    assign M_AXI_WDATA   = wdata_reg;
    assign M_AXI_WSTRB   = wstrb_reg;
    assign M_AXI_WVALID  = wvalid_reg;
    assign M_AXI_BREADY  = bready_reg;
    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_reg;
    assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: delay-configurable AXI4-Lite slave model, table of commands,
// response scoreboard, plus timeout and mid-transaction reset sequences.
module tb_axi_lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Slave model: each READY rises <delay> cycles after its VALID is seen; responses follow
    // <delay> cycles after the request side completes.
    int          cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
    logic        cfg_b_never = 1'b0;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int          aw_beats, w_beats, ar_beats;
    logic        aw_got, w_got, ar_got;
    logic [15:0] last_awaddr, last_araddr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; arready <= 1'b0; rvalid <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_beats <= 0; w_beats <= 0; ar_beats <= 0;
            last_awaddr <= '0; last_araddr <= '0; last_wdata <= '0; last_wstrb <= '0;
        end else begin
            if (awvalid && awready) begin
                awready <= 1'b0; aw_cnt <= 0; aw_got <= 1'b1;
                aw_beats <= aw_beats + 1; last_awaddr <= awaddr;
            end else if (awvalid) begin
                if (aw_cnt == cfg_aw_d) awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                wready <= 1'b0; w_cnt <= 0; w_got <= 1'b1;
                w_beats <= w_beats + 1; last_wdata <= wdata; last_wstrb <= wstrb;
            end else if (wvalid) begin
                if (w_cnt == cfg_w_d) wready <= 1'b1; else w_cnt <= w_cnt + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else if (aw_got && w_got && !bvalid && !cfg_b_never) begin
                if (b_cnt == cfg_b_d) begin bvalid <= 1'b1; bresp <= cfg_resp; end
                else b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin
                arready <= 1'b0; ar_cnt <= 0; ar_got <= 1'b1;
                ar_beats <= ar_beats + 1; last_araddr <= araddr;
            end else if (arvalid) begin
                if (ar_cnt == cfg_ar_d) arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
            end else if (ar_got && !rvalid) begin
                if (r_cnt == cfg_r_d) begin rvalid <= 1'b1; rresp <= cfg_resp; rdata <= cfg_rdata; end
                else r_cnt <= r_cnt + 1;
            end
        end
    end

    // Protocol monitors, sampled mid-cycle.
    int bready_early = 0, rready_gap = 0, valid_after_hs = 0, prot_bad = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bready && !(aw_got && w_got)) bready_early <= bready_early + 1;
            if (ar_got && !rvalid && !rready) rready_gap <= rready_gap + 1;
            if ((awvalid && aw_got) || (wvalid && w_got)) valid_after_hs <= valid_after_hs + 1;
            if (awprot != 3'b000 || arprot != 3'b000) prot_bad <= prot_bad + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        timeout;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  slv_resp;
        logic [31:0] slv_rdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          hold;
    } vec_t;

    // Issue one command, measure accept -> rsp_valid latency, hold the response, then consume it.
    task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [1:0] e_resp, input logic [31:0] e_rdata,
                          input logic e_to, input int e_lat, input int hold, input string tag);
        int   guard;
        int   n;
        exp_t got;
        exp_t e;
        @(negedge clk);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        if (guard == 100) begin
            check({tag, "_accept_timeout"}, 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back('{resp: e_resp, rdata: e_rdata, timeout: e_to});
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check({tag, "_latency"}, 64'(n), 64'(e_lat));
        if (!rsp_valid) return;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, "_hold_fields"}, {29'd0, rsp_timeout, rsp_resp, rsp_rdata}, {29'd0, e_to, e_resp, e_rdata});
        end
        got = '{resp: rsp_resp, rdata: rsp_rdata, timeout: rsp_timeout};
        rsp_ready = 1'b1;
        @(posedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_rsp"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_resp"}, 64'(got.resp), 64'(e.resp));
            check({tag, "_rdata"}, 64'(got.rdata), 64'(e.rdata));
            check({tag, "_timeout"}, 64'(got.timeout), 64'(e.timeout));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_dropped"}, 64'(rsp_valid), 64'd0);
        check({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
        $display("txn %s wr=%0b addr=0x%0h resp=%0b rdata=0x%0h to=%0b lat=%0d",
                 tag, wr, addr, got.resp, got.rdata, got.timeout, n);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int aw0, w0, ar0;
        int guard;
        string tag;

        vecs[0] = '{1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 32'h0, 4, 0};
        vecs[1] = '{1'b1, 16'h0010, 32'h0000A5A5, 4'h3, 3, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 32'h0, 7, 1};
        vecs[2] = '{1'b0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b00, 32'h12345678, 2'b00, 32'h12345678, 9, 0};
        vecs[3] = '{1'b1, 16'h0008, 32'h00C0FFEE, 4'h1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 2'b10, 32'h0, 4, 2};
        vecs[4] = '{1'b0, 16'h000C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'hCAFEF00D, 2'b11, 32'hCAFEF00D, 4, 0};
        vecs[5] = '{1'b0, 16'h0020, 32'h0, 4'h0, 0, 0, 0, 2, 0, 2'b00, 32'h0BADF00D, 2'b00, 32'h0BADF00D, 6, 0};

        // Reset values.
        #2;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valids", {59'd0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
        check("rst_rsp", {29'd0, rsp_valid, rsp_timeout, rsp_resp}, 64'd0);
        check("rst_payload", {awaddr, araddr, wdata}, 64'd0);
        check("rst_rdata_wstrb", {28'd0, wstrb, rsp_rdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            cfg_aw_d = vecs[i].aw_d; cfg_w_d = vecs[i].w_d; cfg_b_d = vecs[i].b_d;
            cfg_ar_d = vecs[i].ar_d; cfg_r_d = vecs[i].r_d;
            cfg_resp = vecs[i].slv_resp; cfg_rdata = vecs[i].slv_rdata;
            aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;
            tag = $sformatf("v%0d", i);
            do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_resp,
                   vecs[i].exp_rdata, 1'b0, vecs[i].exp_lat, vecs[i].hold, tag);
            if (vecs[i].wr) begin
                check({tag, "_aw_beats"}, 64'(aw_beats - aw0), 64'd1);
                check({tag, "_w_beats"}, 64'(w_beats - w0), 64'd1);
                check({tag, "_awaddr"}, 64'(last_awaddr), 64'(vecs[i].addr));
                check({tag, "_wdata"}, 64'(last_wdata), 64'(vecs[i].wdata));
                check({tag, "_wstrb"}, 64'(last_wstrb), 64'(vecs[i].wstrb));
            end else begin
                check({tag, "_ar_beats"}, 64'(ar_beats - ar0), 64'd1);
                check({tag, "_araddr"}, 64'(last_araddr), 64'(vecs[i].addr));
            end
        end

        // Timeout: BVALID never comes; response 16 cycles after accept, held for 10 cycles.
        cfg_aw_d = 0; cfg_w_d = 0; cfg_b_never = 1'b1;
        do_cmd(1'b1, 16'h0030, 32'h11112222, 4'hF, 2'b10, 32'h0, 1'b1, 16, 10, "timeout");
        check("timeout_bready_low", 64'(bready), 64'd0);
        cfg_b_never = 1'b0;
        reset_pulse();

        // Reset while AWVALID is held: everything clears at once and no response appears.
        cfg_aw_d = 8; cfg_w_d = 8;
        @(negedge clk);
        cmd_write = 1'b1; cmd_addr = 16'h0040; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("midrst_awvalid_before", 64'(awvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_valids", {59'd0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
        check("midrst_rsp_busy", {62'd0, rsp_valid, busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        cfg_aw_d = 0; cfg_w_d = 0; cfg_ar_d = 0; cfg_r_d = 1; cfg_resp = 2'b00; cfg_rdata = 32'h600DCAFE;
        do_cmd(1'b0, 16'h0044, 32'h0, 4'h0, 2'b00, 32'h600DCAFE, 1'b0, 5, 0, "post_rst_read");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("bready_before_aw_w", 64'(bready_early), 64'd0);
        check("rready_gap", 64'(rready_gap), 64'd0);
        check("valid_after_handshake", 64'(valid_after_hs), 64'd0);
        check("prot_nonzero", 64'(prot_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
